// File: rtl/clk_gate_ctrl.sv
// Purpose: clock-gate controller; wakes a shared gated domain on request and parks it after an idle hysteresis.
// Latency: en_o rises 1 cycle after a request in OFF; ack_o follows WakeCycles later; en_o falls IdleCycles+1 after quiet.
// Backpressure: requesters hold req_i until ack_o; busy_i holds the clock on but never wakes an OFF domain.
module clk_gate_ctrl #(
    parameter int NumReq     = 4,
    parameter int WakeCycles = 2,
    parameter int IdleCycles = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              busy_i,
    output logic [NumReq-1:0] ack_o,
    output logic              en_o,
    output logic              active_o
);

    // One counter times both WAKE and IDLE, so it is sized for the longer of the two.
    localparam int CntMax = (WakeCycles > IdleCycles) ? WakeCycles : IdleCycles;
    localparam int CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);
    localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            en_q;
    logic            any_req;
    logic            quiet;

    assign any_req = |req_i;
    assign quiet   = !any_req && !busy_i;

    // Next-state and counter decisions; WAKE always runs to completion regardless of req_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (any_req) begin
                    state_d = WAKE;
                    cnt_d   = WakeLoad;
                end
            end
            WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ON;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ON: begin
                if (quiet) begin
                    state_d = IDLE;
                    cnt_d   = IdleLoad;
                end
            end
            IDLE: begin
                // A new request or busy work takes priority over the expiring counter.
                if (!quiet) begin
                    state_d = ON;
                end else if (cnt_q == '0) begin
                    state_d = OFF;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate enable is its own flop, loaded from the next state so it is glitch-free at the gating cell.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q <= 1'b0;
        end else begin
            en_q <= (state_d != OFF);
        end
    end

    assign en_o     = en_q;
    assign active_o = en_q;
    // Grants pass straight through only while the gated clock is running and stable.
    assign ack_o    = (state_q == ON) ? req_i : '0;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

    localparam int NumReq = 4;

    logic              clk_i;
    logic              rst_ni;
    logic [NumReq-1:0] req_i;
    logic              busy_i;
    logic [NumReq-1:0] ack_o;
    logic              en_o;
    logic              active_o;

    int n_tests;
    int n_fail;

    clk_gate_ctrl #(
        .NumReq    (NumReq),
        .WakeCycles(2),
        .IdleCycles(8)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .busy_i  (busy_i),
        .ack_o   (ack_o),
        .en_o    (en_o),
        .active_o(active_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one cycle: inputs are driven 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well away from the edge).
    task automatic settle();
        #2;
    endtask

    // Drive the domain from OFF into ON with the given request; leaves it at cycle 3 (ON).
    task automatic go_on(input logic [NumReq-1:0] r);
        req_i  = r;
        busy_i = 1'b0;
        step();
        step();
        step();
    endtask

    // Quiet everything long enough to be sure the domain is back in OFF.
    task automatic go_off();
        req_i  = '0;
        busy_i = 1'b0;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i  = 4'b1111;
        busy_i = 1'b1;
        repeat (3) step();
        settle();
        n_tests++;
        if (en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en: got %b want 0", en_o);
        end
        n_tests++;
        if (active_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active: got %b want 0", active_o);
        end
        n_tests++;
        if (ack_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ack: got %b want 0000", ack_o);
        end
        req_i  = '0;
        busy_i = 1'b0;
        #2 rst_ni = 1'b1;
        step();
    endtask

    task automatic test_cold_wake();
        logic       exp_en  [4];
        logic [3:0] exp_ack [4];
        exp_en  = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_ack = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
        req_i = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) step();
            settle();
            n_tests++;
            if (en_o !== exp_en[c] || active_o !== exp_en[c]) begin
                n_fail++;
                $display("FAIL cold_wake_en c%0d: got en=%b active=%b want %b", c, en_o, active_o, exp_en[c]);
            end
            n_tests++;
            if (ack_o !== exp_ack[c]) begin
                n_fail++;
                $display("FAIL cold_wake_ack c%0d: got %b want %b", c, ack_o, exp_ack[c]);
            end
        end
        go_off();
    endtask

    task automatic test_busy_no_wake();
        busy_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            settle();
            n_tests++;
            if (en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_no_wake c%0d: got en=%b want 0", c, en_o);
            end
        end
        busy_i = 1'b0;
        step();
    endtask

    task automatic test_idle_timeout();
        go_on(4'b0001);
        req_i = '0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) step();
            settle();
            n_tests++;
            if (en_o !== (k < 9) || active_o !== en_o) begin
                n_fail++;
                $display("FAIL idle_timeout t+%0d: got en=%b active=%b want en=%b", k, en_o, active_o, (k < 9));
            end
            n_tests++;
            if (ack_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_timeout_ack t+%0d: got %b want 0000", k, ack_o);
            end
        end
        go_off();
    endtask

    task automatic test_idle_rescue();
        go_on(4'b1000);
        req_i = '0;
        for (int k = 1; k <= 3; k++) step();
        req_i = 4'b0100;
        settle();
        n_tests++;
        if (ack_o !== 4'b0000 || en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_rescue_in_idle: got ack=%b en=%b want ack=0000 en=1", ack_o, en_o);
        end
        step();
        settle();
        n_tests++;
        if (ack_o !== 4'b0100 || en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_rescue_on: got ack=%b en=%b want ack=0100 en=1", ack_o, en_o);
        end
        go_off();
    endtask

    task automatic test_busy_hold();
        go_on(4'b0010);
        req_i  = '0;
        busy_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            settle();
            n_tests++;
            if (en_o !== 1'b1 || ack_o !== 4'b0000) begin
                n_fail++;
                $display("FAIL busy_hold c%0d: got en=%b ack=%b want en=1 ack=0000", k, en_o, ack_o);
            end
        end
        busy_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            settle();
            n_tests++;
            if (en_o !== (k < 9)) begin
                n_fail++;
                $display("FAIL busy_release t+%0d: got en=%b want %b", k, en_o, (k < 9));
            end
        end
        go_off();
    endtask

    task automatic test_edge_race();
        go_on(4'b0001);
        req_i = '0;
        for (int k = 1; k <= 8; k++) step();
        req_i = 4'b0010;
        settle();
        n_tests++;
        if (en_o !== 1'b1 || ack_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL edge_race_cnt0: got en=%b ack=%b want en=1 ack=0000", en_o, ack_o);
        end
        step();
        settle();
        n_tests++;
        if (en_o !== 1'b1 || ack_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL edge_race_on: got en=%b ack=%b want en=1 ack=0010", en_o, ack_o);
        end
        go_off();
    endtask

    task automatic test_wake_ignore();
        req_i = 4'b0001;
        step();
        req_i = '0;
        step();
        step();
        settle();
        n_tests++;
        if (en_o !== 1'b1 || ack_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL wake_ignore_on: got en=%b ack=%b want en=1 ack=0000", en_o, ack_o);
        end
        for (int k = 1; k <= 9; k++) step();
        settle();
        n_tests++;
        if (en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_ignore_off: got en=%b want 0", en_o);
        end
        go_off();
    endtask

    task automatic test_concurrent();
        go_on(4'b1011);
        settle();
        n_tests++;
        if (ack_o !== 4'b1011) begin
            n_fail++;
            $display("FAIL concurrent_ack: got %b want 1011", ack_o);
        end
        req_i = 4'b0110;
        settle();
        n_tests++;
        if (ack_o !== 4'b0110) begin
            n_fail++;
            $display("FAIL concurrent_comb: got %b want 0110", ack_o);
        end
        go_off();
    endtask

    task automatic test_reset_mid();
        go_on(4'b1111);
        settle();
        n_tests++;
        if (ack_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got ack=%b want 1111", ack_o);
        end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (en_o !== 1'b0 || ack_o !== 4'b0000 || active_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got en=%b ack=%b active=%b want 0/0000/0", en_o, ack_o, active_o);
        end
        step();
        #2 rst_ni = 1'b1;
        step();
        settle();
        n_tests++;
        if (en_o !== 1'b1 || ack_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_rewake: got en=%b ack=%b want en=1 ack=0000", en_o, ack_o);
        end
        step();
        step();
        settle();
        n_tests++;
        if (ack_o !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_mid_reack: got ack=%b want 1111", ack_o);
        end
        go_off();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_ni  = 1'b0;
        req_i   = '0;
        busy_i  = 1'b0;
        test_reset();
        test_cold_wake();
        test_busy_no_wake();
        test_idle_timeout();
        test_idle_rescue();
        test_busy_hold();
        test_edge_race();
        test_wake_ignore();
        test_concurrent();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
